// File: rtl/pu_pkg.sv
// Shared constants for the PU feeder: calc-state codes, FSM encoding, default sizes.
package pu_pkg;

    localparam int unsigned DEF_COLS      = 5;
    localparam int unsigned DEF_ROWS      = 5;
    localparam int unsigned DEF_T_COLS    = 5;
    localparam int unsigned DEF_T_ROWS    = 5;
    localparam int unsigned DEF_I_F_BW    = 8;
    localparam int unsigned DEF_W_BW      = 8;
    localparam int unsigned DEF_B_BW      = 8;
    localparam int unsigned DEF_ACT_BW    = 8;
    localparam int unsigned DEF_K_BW      = 8;
    localparam int unsigned DEF_DRAIN_CYC = 6;

    localparam logic [1:0] CS_IDLE  = 2'b00;
    localparam logic [1:0] CS_FIRST = 2'b01;
    localparam logic [1:0] CS_ACC   = 2'b10;
    localparam logic [1:0] CS_FLUSH = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FEED  = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;
    localparam logic [1:0] ST_OUT   = 2'b11;

endpackage

// File: rtl/pu_feeder.sv
// Feeds a job's fmap/weight beats into the PU array, waits out the PU pipeline,
// then presents the captured activation row with a valid/ready handshake.
module pu_feeder
    import pu_pkg::*;
#(
    parameter int unsigned COLS      = DEF_COLS,
    parameter int unsigned ROWS      = DEF_ROWS,
    parameter int unsigned T_COLS    = DEF_T_COLS,
    parameter int unsigned T_ROWS    = DEF_T_ROWS,
    parameter int unsigned I_F_BW    = DEF_I_F_BW,
    parameter int unsigned W_BW      = DEF_W_BW,
    parameter int unsigned B_BW      = DEF_B_BW,
    parameter int unsigned ACT_BW    = DEF_ACT_BW,
    parameter int unsigned K_BW      = DEF_K_BW,
    parameter int unsigned DRAIN_CYC = DEF_DRAIN_CYC
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_start,
    input  logic [2:0]                      i_layer,
    input  logic [B_BW-1:0]                 i_bias,
    input  logic [K_BW-1:0]                 i_num_k,
    input  logic                            i_src_valid,
    output logic                            o_src_ready,
    input  logic [I_F_BW*ROWS*T_ROWS-1:0]   i_src_fmap,
    input  logic [W_BW*COLS*T_COLS-1:0]     i_src_weight,
    output logic                            o_en_tf,
    output logic [1:0]                      o_cal_state,
    output logic [2:0]                      o_layer_state,
    output logic [I_F_BW*ROWS*T_ROWS-1:0]   o_fmap,
    output logic [W_BW*COLS*T_COLS-1:0]     o_weight,
    output logic [B_BW-1:0]                 o_bias,
    input  logic [ACT_BW*COLS*T_COLS-1:0]   i_act_data,
    output logic                            o_res_valid,
    input  logic                            i_res_ready,
    output logic [ACT_BW*COLS*T_COLS-1:0]   o_res_data,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int unsigned FMAP_W = I_F_BW * ROWS * T_ROWS;
    localparam int unsigned WGT_W  = W_BW * COLS * T_COLS;
    localparam int unsigned ACT_W  = ACT_BW * COLS * T_COLS;

    logic [1:0]        state_q,     state_d;
    logic [K_BW-1:0]   cnt_q,       cnt_d;      // beats remaining in FEED, drain cycles left in DRAIN
    logic              first_q,     first_d;
    logic              en_tf_q,     en_tf_d;
    logic [1:0]        cal_q,       cal_d;
    logic [2:0]        layer_q,     layer_d;
    logic [B_BW-1:0]   bias_q,      bias_d;
    logic [FMAP_W-1:0] fmap_q,      fmap_d;
    logic [WGT_W-1:0]  weight_q,    weight_d;
    logic              res_valid_q, res_valid_d;
    logic [ACT_W-1:0]  res_data_q,  res_data_d;
    logic              fire_c;

    // A beat moves whenever upstream offers one while we are feeding
    assign fire_c = i_src_valid && (state_q == ST_FEED);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        first_d     = first_q;
        en_tf_d     = 1'b0;
        cal_d       = CS_IDLE;
        layer_d     = layer_q;
        bias_d      = bias_q;
        fmap_d      = fmap_q;
        weight_d    = weight_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    layer_d = i_layer;
                    bias_d  = i_bias;
                    cnt_d   = (i_num_k == '0) ? K_BW'(1) : i_num_k;
                    first_d = 1'b1;
                    state_d = ST_FEED;
                end
            end
            ST_FEED: begin
                if (fire_c) begin
                    en_tf_d  = 1'b1;
                    fmap_d   = i_src_fmap;
                    weight_d = i_src_weight;
                    cal_d    = first_q ? CS_FIRST : CS_ACC;
                    first_d  = 1'b0;
                    // Last beat: reuse the counter to time the PU pipeline drain
                    if (cnt_q == K_BW'(1)) begin
                        cnt_d   = K_BW'(DRAIN_CYC);
                        state_d = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q - K_BW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0) begin
                    res_data_d  = i_act_data;
                    res_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else begin
                    cnt_d = cnt_q - K_BW'(1);
                    cal_d = CS_FLUSH;
                end
            end
            ST_OUT: begin
                if (i_res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            first_q     <= 1'b0;
            en_tf_q     <= 1'b0;
            cal_q       <= CS_IDLE;
            layer_q     <= '0;
            bias_q      <= '0;
            fmap_q      <= '0;
            weight_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            en_tf_q     <= en_tf_d;
            cal_q       <= cal_d;
            layer_q     <= layer_d;
            bias_q      <= bias_d;
            fmap_q      <= fmap_d;
            weight_q    <= weight_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign o_src_ready   = (state_q == ST_FEED);
    assign o_busy        = (state_q != ST_IDLE);
    assign o_done        = (state_q == ST_OUT) && i_res_ready;
    assign o_en_tf       = en_tf_q;
    assign o_cal_state   = cal_q;
    assign o_layer_state = layer_q;
    assign o_bias        = bias_q;
    assign o_fmap        = fmap_q;
    assign o_weight      = weight_q;
    assign o_res_valid   = res_valid_q;
    assign o_res_data    = res_data_q;

endmodule

// File: tb/tb_pu_feeder.sv
// Randomized bench for pu_feeder with a transaction-level reference model.
module tb_pu_feeder;

    localparam int unsigned BW    = 200;
    localparam int          DRAIN = 6;
    localparam logic [1:0]  C_IDLE  = 2'b00;
    localparam logic [1:0]  C_FIRST = 2'b01;
    localparam logic [1:0]  C_ACC   = 2'b10;
    localparam logic [1:0]  C_FLUSH = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic [2:0]    i_layer;
    logic [7:0]    i_bias;
    logic [7:0]    i_num_k;
    logic          i_src_valid;
    logic          o_src_ready;
    logic [BW-1:0] i_src_fmap;
    logic [BW-1:0] i_src_weight;
    logic          o_en_tf;
    logic [1:0]    o_cal_state;
    logic [2:0]    o_layer_state;
    logic [BW-1:0] o_fmap;
    logic [BW-1:0] o_weight;
    logic [7:0]    o_bias;
    logic [BW-1:0] i_act_data;
    logic          o_res_valid;
    logic          i_res_ready;
    logic [BW-1:0] o_res_data;
    logic          o_busy;
    logic          o_done;

    pu_feeder dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_layer(i_layer), .i_bias(i_bias),
        .i_num_k(i_num_k), .i_src_valid(i_src_valid), .o_src_ready(o_src_ready),
        .i_src_fmap(i_src_fmap), .i_src_weight(i_src_weight), .o_en_tf(o_en_tf),
        .o_cal_state(o_cal_state), .o_layer_state(o_layer_state), .o_fmap(o_fmap),
        .o_weight(o_weight), .o_bias(o_bias), .i_act_data(i_act_data),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready), .o_res_data(o_res_data),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    // Per-job record filled by run_job
    logic [BW-1:0] sent_f[$], sent_w[$], obs_f[$], obs_w[$];
    logic [1:0]    obs_c[$];
    bit            en_hist[$];
    int            flush_n, done_n, done_bad, busy_bad, lay_bad, bias_bad, hold_bad, res_unstable;
    int            last_en, valid_cyc, done_cyc;
    bit            timeout;
    logic          post_busy, post_done;
    logic [2:0]    post_layer;
    logic [7:0]    post_bias;
    logic [BW-1:0] res_exp, res_first;

    function automatic logic [BW-1:0] rnd_bus();
        logic [BW-1:0] v = '0;
        for (int i = 0; i < int'((BW + 31) / 32); i++) v = (v << 32) | BW'($urandom);
        return v;
    endfunction

    function automatic string en_trace();
        string s = "";
        int f = -1;
        int l = -1;
        foreach (en_hist[i]) if (en_hist[i]) begin if (f < 0) f = i; l = i; end
        if (f >= 0) for (int i = f; i <= l; i++) s = {s, en_hist[i] ? "1" : "0"};
        return s;
    endfunction

    function automatic int beat_mismatches();
        int m = 0;
        if (sent_f.size() != obs_f.size()) return 9999;
        foreach (sent_f[i]) if (sent_f[i] !== obs_f[i] || sent_w[i] !== obs_w[i]) m++;
        return m;
    endfunction

    function automatic int cal_mismatches();
        int m = 0;
        foreach (obs_c[i]) if (obs_c[i] !== ((i == 0) ? C_FIRST : C_ACC)) m++;
        return m;
    endfunction

    // Drive one job from start to result handshake, recording what the PU side sees
    task automatic run_job(input int k, input logic [2:0] layer, input logic [7:0] bias,
                           input int vpct, input int stall_after, input int stall_len,
                           input int ready_lo, input bit inject, input bit start_on_done,
                           input logic [2:0] nxt_layer, input logic [7:0] nxt_bias);
        bit en_seen = 0;
        bit seen_valid = 0;
        bit finished = 0;
        bit stall;
        int out_n = 0;
        int stall_done = 0;
        logic [BW-1:0] last_f = '0;
        logic [BW-1:0] act_prev = '0;
        sent_f.delete(); sent_w.delete(); obs_f.delete(); obs_w.delete(); obs_c.delete(); en_hist.delete();
        flush_n = 0; done_n = 0; done_bad = 0; busy_bad = 0; lay_bad = 0; bias_bad = 0;
        hold_bad = 0; res_unstable = 0; last_en = -1; valid_cyc = -1; done_cyc = -1; timeout = 0;
        i_layer = layer; i_bias = bias; i_num_k = 8'(k); i_start = 1'b1;
        i_src_valid = 1'b0; i_res_ready = 1'b0;
        for (int n = 0; n < 4000 && !finished; n++) begin
            @(posedge clk); #1;
            i_start = 1'b0;
            en_hist.push_back(o_en_tf);
            if (o_en_tf) begin
                obs_f.push_back(o_fmap); obs_w.push_back(o_weight); obs_c.push_back(o_cal_state);
                last_en = cyc; en_seen = 1; last_f = o_fmap;
            end else if (en_seen && o_fmap !== last_f) hold_bad++;
            if (o_cal_state === C_FLUSH) flush_n++;
            if (o_layer_state !== layer) lay_bad++;
            if (o_bias !== bias) bias_bad++;
            if (o_busy !== 1'b1) busy_bad++;
            if (o_res_valid) begin
                if (!seen_valid) begin
                    seen_valid = 1; valid_cyc = cyc; res_exp = act_prev; res_first = o_res_data;
                end else if (o_res_data !== res_first) res_unstable++;
            end
            stall = (sent_f.size() == stall_after) && (stall_done < stall_len);
            if (stall) stall_done++;
            i_src_valid  = !stall && ($urandom_range(99) < vpct);
            i_src_fmap   = rnd_bus();
            i_src_weight = rnd_bus();
            i_act_data   = rnd_bus();
            i_layer      = 3'($urandom);
            i_bias       = 8'($urandom);
            i_res_ready  = o_res_valid && (out_n >= ready_lo);
            if (o_res_valid) out_n++;
            if (inject && sent_f.size() == 1) i_start = 1'b1;
            if (start_on_done && i_res_ready) begin
                i_start = 1'b1; i_layer = nxt_layer; i_bias = nxt_bias; i_num_k = 8'd1;
            end
            #1;
            if (i_src_valid && o_src_ready) begin
                sent_f.push_back(i_src_fmap); sent_w.push_back(i_src_weight);
            end
            act_prev = i_act_data;
            if (o_done) begin
                done_n++; done_cyc = cyc;
                if (!(o_res_valid && i_res_ready)) done_bad++;
                finished = 1;
            end
        end
        if (!finished) timeout = 1;
        @(posedge clk); #1;
        i_start = 1'b0; i_src_valid = 1'b0; i_res_ready = 1'b1;
        #1;
        post_busy = o_busy; post_done = o_done; post_layer = o_layer_state; post_bias = o_bias;
        i_res_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (o_en_tf !== 1'b0) begin errors++; $display("FAIL rst_en_tf: got %b expected 0", o_en_tf); end
        checks++; if (o_cal_state !== C_IDLE) begin errors++; $display("FAIL rst_cal: got %b expected %b", o_cal_state, C_IDLE); end
        checks++; if (o_layer_state !== 3'd0 || o_bias !== 8'd0) begin errors++; $display("FAIL rst_layer_bias: got %b/%h expected 0/0", o_layer_state, o_bias); end
        checks++; if (o_fmap !== '0 || o_weight !== '0 || o_res_data !== '0) begin errors++; $display("FAIL rst_data: got %h expected 0", o_fmap | o_weight | o_res_data); end
        checks++; if ({o_src_ready, o_res_valid, o_busy, o_done} !== 4'b0) begin errors++; $display("FAIL rst_ctrl: got %b expected 0000", {o_src_ready, o_res_valid, o_busy, o_done}); end
    endtask

    task automatic test_basic();
        run_job(3, 3'b011, 8'h21, 100, -1, 0, 0, 0, 0, 3'b0, 8'h0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL basic_timeout: got %b expected 0", timeout); end
        checks++; if (en_trace() != "111") begin errors++; $display("FAIL basic_en_trace: got %s expected 111", en_trace()); end
        checks++; if (cal_mismatches() !== 0) begin errors++; $display("FAIL basic_cal: got %0d bad expected 0", cal_mismatches()); end
        checks++; if (beat_mismatches() !== 0) begin errors++; $display("FAIL basic_data: got %0d bad expected 0", beat_mismatches()); end
        checks++; if (valid_cyc - last_en !== 1 + DRAIN) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", valid_cyc - last_en, 1 + DRAIN); end
        checks++; if (flush_n !== DRAIN) begin errors++; $display("FAIL basic_flush: got %0d expected %0d", flush_n, DRAIN); end
        checks++; if (res_first !== res_exp) begin errors++; $display("FAIL basic_res: got %h expected %h", res_first, res_exp); end
        checks++; if (done_n !== 1 || post_done !== 1'b0 || post_busy !== 1'b0) begin errors++; $display("FAIL basic_done: got %0d/%b/%b expected 1/0/0", done_n, post_done, post_busy); end
        checks++; if (busy_bad !== 0 || lay_bad !== 0 || bias_bad !== 0) begin errors++; $display("FAIL basic_busy_cfg: got %0d/%0d/%0d expected 0/0/0", busy_bad, lay_bad, bias_bad); end
    endtask

    task automatic test_stall();
        run_job(4, 3'b001, 8'h10, 100, 2, 2, 0, 0, 0, 3'b0, 8'h0);
        checks++; if (en_trace() != "110011") begin errors++; $display("FAIL stall_en_trace: got %s expected 110011", en_trace()); end
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d bad expected 0", hold_bad); end
        checks++; if (beat_mismatches() !== 0) begin errors++; $display("FAIL stall_data: got %0d bad expected 0", beat_mismatches()); end
        checks++; if (cal_mismatches() !== 0) begin errors++; $display("FAIL stall_cal: got %0d bad expected 0", cal_mismatches()); end
    endtask

    task automatic test_backpressure();
        run_job(int'($urandom_range(6, 1)), 3'b100, 8'h44, 60, -1, 0, 5, 0, 0, 3'b0, 8'h0);
        checks++; if (res_unstable !== 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", res_unstable); end
        checks++; if (done_cyc - valid_cyc !== 5) begin errors++; $display("FAIL bp_wait: got %0d expected 5", done_cyc - valid_cyc); end
        checks++; if (done_n !== 1 || done_bad !== 0) begin errors++; $display("FAIL bp_done: got %0d/%0d expected 1/0", done_n, done_bad); end
        checks++; if (res_first !== res_exp) begin errors++; $display("FAIL bp_res: got %h expected %h", res_first, res_exp); end
    endtask

    task automatic test_edge_counts();
        run_job(0, 3'b110, 8'h01, 100, -1, 0, 0, 0, 0, 3'b0, 8'h0);
        checks++; if (obs_f.size() !== 1 || sent_f.size() !== 1) begin errors++; $display("FAIL k0_beats: got %0d/%0d expected 1/1", obs_f.size(), sent_f.size()); end
        checks++; if (cal_mismatches() !== 0 || beat_mismatches() !== 0) begin errors++; $display("FAIL k0_beat: got %0d/%0d expected 0/0", cal_mismatches(), beat_mismatches()); end
        run_job(255, 3'b111, 8'hFE, 80, -1, 0, 1, 0, 0, 3'b0, 8'h0);
        checks++; if (obs_f.size() !== 255 || sent_f.size() !== 255) begin errors++; $display("FAIL k255_beats: got %0d/%0d expected 255/255", obs_f.size(), sent_f.size()); end
        checks++; if (beat_mismatches() !== 0 || cal_mismatches() !== 0) begin errors++; $display("FAIL k255_data: got %0d/%0d expected 0/0", beat_mismatches(), cal_mismatches()); end
        checks++; if (done_n !== 1 || res_first !== res_exp) begin errors++; $display("FAIL k255_done: got %0d expected 1", done_n); end
    endtask

    task automatic test_start_ignore();
        run_job(6, 3'b110, 8'h55, 100, -1, 0, 0, 1, 0, 3'b0, 8'h0);
        checks++; if (lay_bad !== 0 || bias_bad !== 0) begin errors++; $display("FAIL ign_cfg: got %0d/%0d expected 0/0", lay_bad, bias_bad); end
        checks++; if (obs_f.size() !== 6 || done_n !== 1) begin errors++; $display("FAIL ign_beats: got %0d/%0d expected 6/1", obs_f.size(), done_n); end
    endtask

    task automatic test_reset_mid();
        int n_sent = 0;
        int spur = 0;
        i_layer = 3'b111; i_bias = 8'hAA; i_num_k = 8'd5; i_start = 1'b1; i_src_valid = 1'b1;
        for (int n = 0; n < 50 && n_sent < 2; n++) begin
            @(posedge clk); #1;
            i_start = 1'b0; i_src_fmap = rnd_bus(); i_src_weight = rnd_bus();
            #1;
            if (i_src_valid && o_src_ready) n_sent++;
        end
        @(posedge clk); #2;
        checks++; if (n_sent !== 2 || o_en_tf !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %0d/%b expected 2/1", n_sent, o_en_tf); end
        rst_n = 1'b0;
        #1;
        checks++; if ({o_en_tf, o_src_ready, o_res_valid, o_busy, o_done} !== 5'b0 || o_cal_state !== C_IDLE) begin errors++; $display("FAIL rmid_ctrl: got %b/%b expected 00000/00", {o_en_tf, o_src_ready, o_res_valid, o_busy, o_done}, o_cal_state); end
        checks++; if (o_layer_state !== 3'd0 || o_bias !== 8'd0 || o_fmap !== '0 || o_weight !== '0 || o_res_data !== '0) begin errors++; $display("FAIL rmid_data: got %b/%h expected 0/0", o_layer_state, o_bias); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            i_res_ready = 1'b1;
            #1;
            if (o_done || o_res_valid || o_busy) spur++;
        end
        i_res_ready = 1'b0; i_src_valid = 1'b0;
        checks++; if (spur !== 0) begin errors++; $display("FAIL rmid_after: got %0d spurious cycles expected 0", spur); end
    endtask

    task automatic test_back_to_back();
        run_job(2, 3'b101, 8'h7F, 100, -1, 0, 0, 0, 1, 3'b010, 8'h3C);
        checks++; if (lay_bad !== 0 || bias_bad !== 0) begin errors++; $display("FAIL b2b_job1_cfg: got %0d/%0d expected 0/0", lay_bad, bias_bad); end
        checks++; if (post_busy !== 1'b0) begin errors++; $display("FAIL b2b_start_on_done: got busy %b expected 0", post_busy); end
        checks++; if (post_layer !== 3'b101 || post_bias !== 8'h7F) begin errors++; $display("FAIL b2b_hold: got %b/%h expected 101/7f", post_layer, post_bias); end
        run_job(3, 3'b010, 8'h3C, 100, -1, 0, 0, 0, 0, 3'b0, 8'h0);
        checks++; if (lay_bad !== 0 || bias_bad !== 0) begin errors++; $display("FAIL b2b_job2_cfg: got %0d/%0d expected 0/0", lay_bad, bias_bad); end
        checks++; if (post_layer !== 3'b010 || post_bias !== 8'h3C) begin errors++; $display("FAIL b2b_idle_hold: got %b/%h expected 010/3c", post_layer, post_bias); end
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 6; j++) begin
            int k = int'($urandom_range(20, 1));
            run_job(k, 3'($urandom), 8'($urandom), int'($urandom_range(100, 30)), -1, 0,
                    int'($urandom_range(3, 0)), 0, 0, 3'b0, 8'h0);
            checks++; if (timeout !== 1'b0 || obs_f.size() !== k) begin errors++; $display("FAIL rnd%0d_beats: got %0d expected %0d", j, obs_f.size(), k); end
            checks++; if (beat_mismatches() !== 0 || cal_mismatches() !== 0 || hold_bad !== 0) begin errors++; $display("FAIL rnd%0d_data: got %0d/%0d/%0d expected 0/0/0", j, beat_mismatches(), cal_mismatches(), hold_bad); end
            checks++; if (valid_cyc - last_en !== 1 + DRAIN || res_first !== res_exp) begin errors++; $display("FAIL rnd%0d_result: got latency %0d expected %0d", j, valid_cyc - last_en, 1 + DRAIN); end
            checks++; if (done_n !== 1 || done_bad !== 0 || busy_bad !== 0 || lay_bad !== 0) begin errors++; $display("FAIL rnd%0d_ctrl: got %0d/%0d/%0d/%0d expected 1/0/0/0", j, done_n, done_bad, busy_bad, lay_bad); end
        end
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_layer = '0; i_bias = '0; i_num_k = '0;
        i_src_valid = 1'b0; i_src_fmap = '0; i_src_weight = '0; i_act_data = '0; i_res_ready = 1'b0;
        #12;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #2;
        test_basic();
        test_stall();
        test_backpressure();
        test_edge_counts();
        test_start_ignore();
        test_back_to_back();
        test_random_jobs();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pu_feeder.md
PU_FEEDER -- requirements
Module: pu_feeder

Interface
REQ-001 SHALL have parameters: COLS 5, systolic columns; ROWS 5, systolic rows; T_COLS 5, tile columns; T_ROWS 5, tile rows; I_F_BW 8, fmap width; W_BW 8, weight width; B_BW 8, bias width; ACT_BW 8, activation width; K_BW 8, beat-count width; DRAIN_CYC 6, PU pipeline depth in cycles.
REQ-002 SHALL have ports: clk in 1, clock; rst_n in 1, reset (one clock; asynchronous, active-low).
REQ-003 SHALL have ports: i_start in 1, start job; i_layer in 3, layer code; i_bias in B_BW, job bias; i_num_k in K_BW, beats per job.
REQ-004 SHALL have ports: i_src_valid in 1; o_src_ready out 1; i_src_fmap in I_F_BW*ROWS*T_ROWS; i_src_weight in W_BW*COLS*T_COLS (upstream beat stream).
REQ-005 SHALL have ports: o_en_tf out 1; o_cal_state out 2; o_layer_state out 3; o_fmap out I_F_BW*ROWS*T_ROWS; o_weight out W_BW*COLS*T_COLS; o_bias out B_BW; i_act_data in ACT_BW*COLS*T_COLS (PU side).
REQ-006 SHALL have ports: o_res_valid out 1; i_res_ready in 1; o_res_data out ACT_BW*COLS*T_COLS; o_busy out 1; o_done out 1.

Function
REQ-007 SHALL implement FSM states IDLE, FEED, DRAIN, OUT.
REQ-008 IDLE: i_start=1 SHALL latch i_layer, i_bias, and effective count (i_num_k, or 1 when i_num_k=0), then enter FEED next cycle.
REQ-009 o_src_ready SHALL be 1 only in FEED while beats remain; a beat transfers on i_src_valid&&o_src_ready.
REQ-010 Each transferred beat SHALL appear registered on o_fmap/o_weight with o_en_tf=1 exactly one cycle later.
REQ-011 o_cal_state SHALL be CS_FIRST for the first beat of a job, CS_ACC for later beats, CS_FLUSH during DRAIN, and CS_IDLE otherwise.
REQ-012 Cycles without a transfer in FEED SHALL drive o_en_tf=0, hold o_fmap/o_weight, and leave the beat counter unchanged.
REQ-013 After the last beat transfers, the FSM SHALL enter DRAIN and count DRAIN_CYC cycles after the last o_en_tf=1 cycle.
REQ-014 On the final DRAIN cycle, the block SHALL capture i_act_data into o_res_data and enter OUT, with o_res_valid=1 the next cycle.
REQ-015 OUT SHALL hold o_res_valid and o_res_data stable until i_res_ready=1.
REQ-016 On the o_res_valid&&i_res_ready cycle, the FSM SHALL return to IDLE and pulse o_done for that single cycle.
REQ-017 o_busy SHALL be 1 in every state except IDLE.
REQ-018 i_start SHALL be ignored outside IDLE.
REQ-019 i_start asserted in the same cycle as the o_done handshake SHALL be ignored; the next job starts one cycle later at the earliest.
REQ-020 o_layer_state SHALL equal the latched layer throughout the job.
REQ-021 o_bias SHALL equal the latched bias throughout the job.
REQ-022 o_layer_state and o_bias SHALL hold their last value in IDLE.
REQ-023 The beat counter SHALL be K_BW wide; i_num_k=255 SHALL produce exactly 255 beats with no wrap.

Reset
REQ-024 On rst_n=0, asynchronously: FSM to IDLE; counters to 0; all outputs to 0 (o_cal_state=CS_IDLE).
REQ-025 Reset mid-job SHALL discard the job; no o_done or o_res_valid follows the release of reset.

Structure
REQ-026 Package pu_pkg SHALL hold CS_IDLE=2'b00, CS_FIRST=2'b01, CS_ACC=2'b10, CS_FLUSH=2'b11.
REQ-027 Package pu_pkg SHALL hold the FSM state encoding and the default parameter values.
REQ-028 pu_feeder SHALL be a single module with no sub-modules; the beat and drain counters SHALL share one counter register.

Verification
REQ-029 Basic job: i_num_k=3, src always valid, i_res_ready=1 -> o_en_tf high 3 consecutive cycles with cal_state FIRST, ACC, ACC; o_res_valid 1+DRAIN_CYC cycles after the last beat; o_done once.
REQ-030 Upstream stall: i_num_k=4, i_src_valid low for 2 cycles after beat 2 -> o_en_tf 1,1,0,0,1,1; o_fmap holds beat-2 data while stalled.
REQ-031 Result backpressure: i_res_ready low for 5 cycles in OUT -> o_res_data stable; o_done only on the handshake cycle.
REQ-032 Edge counts: i_num_k=0 -> exactly 1 beat; i_num_k=255 -> exactly 255 beats.
REQ-033 Reset and start ignore: rst_n low at beat 2 of 5 -> all outputs 0; no o_done after release. i_start pulsed during FEED -> ignored.
REQ-034 Back-to-back jobs: i_layer=3'b101 with i_bias=8'h7F, then i_layer=3'b010 -> o_layer_state/o_bias switch only after the second accepted start.
